ex_operand_stage: RTL and testbench

ID/EX pipeline register that sits directly upstream of the ALU. It latches decoded instruction fields and resolves operand A/B through a forwarding network: in-flight ALU result, MEM stage, WB stage, then register file. It detects load-use hazards and inserts bubbles, and honours downstream stall and branch flush. Its registered outputs drive the ALU `A`, `B` and `operation` inputs directly.

---
 rtl/ex_operand_stage.sv | 135 +++++++++++++
 tb/tb_ex_operand_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: resolves operands through the
// EX/MEM/WB forwarding network, inserts load-use bubbles, honours stall/flush.
module ex_operand_stage #(
  parameter int WORD_SIZE     = 32,
  parameter int REG_ADDR_BITS = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     id_valid,
  output logic                     id_ready,
  input  logic [3:0]               id_alu_op,
  input  logic [REG_ADDR_BITS-1:0] id_rs1_addr,
  input  logic [REG_ADDR_BITS-1:0] id_rs2_addr,
  input  logic                     id_rs1_used,
  input  logic                     id_rs2_used,
  input  logic [WORD_SIZE-1:0]     id_rs1_data,
  input  logic [WORD_SIZE-1:0]     id_rs2_data,
  input  logic [WORD_SIZE-1:0]     id_imm,
  input  logic                     id_use_imm,
  input  logic [REG_ADDR_BITS-1:0] id_rd_addr,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic [WORD_SIZE-1:0]     ex_alu_result,
  input  logic [REG_ADDR_BITS-1:0] mem_rd_addr,
  input  logic [REG_ADDR_BITS-1:0] wb_rd_addr,
  input  logic                     mem_reg_write,
  input  logic                     wb_reg_write,
  input  logic [WORD_SIZE-1:0]     mem_data,
  input  logic [WORD_SIZE-1:0]     wb_data,
  output logic                     ex_valid,
  output logic [WORD_SIZE-1:0]     ex_A,
  output logic [WORD_SIZE-1:0]     ex_B,
  output logic [WORD_SIZE-1:0]     ex_store_data,
  output logic [3:0]               ex_alu_op,
  output logic [REG_ADDR_BITS-1:0] ex_rd_addr,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     hazard
);

  typedef struct packed {
    logic                     valid;
    logic [3:0]               alu_op;
    logic [WORD_SIZE-1:0]     a;
    logic [WORD_SIZE-1:0]     b;
    logic [WORD_SIZE-1:0]     store;
    logic [REG_ADDR_BITS-1:0] rd;
    logic                     reg_write;
    logic                     mem_read;
  } ex_reg_t;

  localparam ex_reg_t BUBBLE = '0;

  ex_reg_t ex_q;
  ex_reg_t ex_d;

  logic                 ex_fwd_en;
  logic [WORD_SIZE-1:0] rs1_fwd;
  logic [WORD_SIZE-1:0] rs2_fwd;

  // Priority: x0, in-flight ALU result, MEM, WB, register file.
  function automatic logic [WORD_SIZE-1:0] fwd(
    input logic [REG_ADDR_BITS-1:0] addr,
    input logic [WORD_SIZE-1:0]     rf_data,
    input logic                     ex_en,
    input logic [REG_ADDR_BITS-1:0] ex_rd,
    input logic [WORD_SIZE-1:0]     ex_res,
    input logic                     mem_en,
    input logic [REG_ADDR_BITS-1:0] mem_rd,
    input logic [WORD_SIZE-1:0]     mem_val,
    input logic                     wb_en,
    input logic [REG_ADDR_BITS-1:0] wb_rd,
    input logic [WORD_SIZE-1:0]     wb_val
  );
    if (addr == '0)                    return '0;
    else if (ex_en && ex_rd == addr)   return ex_res;
    else if (mem_en && mem_rd == addr) return mem_val;
    else if (wb_en && wb_rd == addr)   return wb_val;
    else                               return rf_data;
  endfunction

  // A load in EX cannot forward its result yet, so only ALU producers qualify.
  assign ex_fwd_en = ex_q.valid & ex_q.reg_write & ~ex_q.mem_read;

  assign rs1_fwd = fwd(id_rs1_addr, id_rs1_data, ex_fwd_en, ex_q.rd, ex_alu_result,
                       mem_reg_write, mem_rd_addr, mem_data,
                       wb_reg_write, wb_rd_addr, wb_data);
  assign rs2_fwd = fwd(id_rs2_addr, id_rs2_data, ex_fwd_en, ex_q.rd, ex_alu_result,
                       mem_reg_write, mem_rd_addr, mem_data,
                       wb_reg_write, wb_rd_addr, wb_data);

  assign hazard = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                  ((id_rs1_used & (id_rs1_addr == ex_q.rd)) |
                   (id_rs2_used & (id_rs2_addr == ex_q.rd)));

  assign id_ready = flush | (~stall & ~hazard);

  always_comb begin
    ex_d = BUBBLE;
    if (flush) begin
      ex_d = BUBBLE;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = BUBBLE;
    end else if (id_valid) begin
      ex_d.valid     = 1'b1;
      ex_d.alu_op    = id_alu_op;
      ex_d.a         = rs1_fwd;
      ex_d.b         = id_use_imm ? id_imm : rs2_fwd;
      ex_d.store     = rs2_fwd;
      ex_d.rd        = id_rd_addr;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
    end
  end

  // ID -> EX boundary
  always_ff @(posedge clk) begin
    if (reset) ex_q <= BUBBLE;
    else       ex_q <= ex_d;
  end

  assign ex_valid      = ex_q.valid;
  assign ex_A          = ex_q.a;
  assign ex_B          = ex_q.b;
  assign ex_store_data = ex_q.store;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_rd_addr    = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, forwarding priority, load-use, stall/flush.
module tb_ex_operand_stage;
  localparam int W = 32;
  localparam int R = 5;

  logic         clk = 1'b0;
  logic         reset, stall, flush, id_valid, id_ready;
  logic [3:0]   id_alu_op;
  logic [R-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr, mem_rd_addr, wb_rd_addr;
  logic         id_rs1_used, id_rs2_used, id_use_imm, id_reg_write, id_mem_read;
  logic [W-1:0] id_rs1_data, id_rs2_data, id_imm, ex_alu_result, mem_data, wb_data;
  logic         mem_reg_write, wb_reg_write;
  logic         ex_valid, ex_reg_write, ex_mem_read, hazard;
  logic [W-1:0] ex_A, ex_B, ex_store_data;
  logic [3:0]   ex_alu_op;
  logic [R-1:0] ex_rd_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.WORD_SIZE(W), .REG_ADDR_BITS(R)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_alu_op(id_alu_op),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_rd_addr(id_rd_addr),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_alu_result(ex_alu_result), .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_data(mem_data), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_store_data(ex_store_data),
    .ex_alu_op(ex_alu_op), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .hazard(hazard)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; stall = 0; flush = 0; id_valid = 0; id_alu_op = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_use_imm = 0;
    id_rd_addr = 0; id_reg_write = 0; id_mem_read = 0; ex_alu_result = 0;
    mem_rd_addr = 0; wb_rd_addr = 0; mem_reg_write = 0; wb_reg_write = 0;
    mem_data = 0; wb_data = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; id_valid = 1; id_alu_op = 4'd5; id_rs1_addr = 1; id_rs1_used = 1;
    id_rs1_data = 32'h11; id_rd_addr = 2; id_reg_write = 1;
    step(); step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ex_valid); end
    checks++; if (ex_A !== 0 || ex_alu_op !== 0 || ex_rd_addr !== 0 || ex_reg_write !== 0)
      begin errors++; $display("FAIL reset_outputs got A=%h op=%0d rd=%0d rw=%0b want zeros", ex_A, ex_alu_op, ex_rd_addr, ex_reg_write); end
    reset = 0;
    step();
    checks++; if (ex_valid !== 1'b1 || ex_A !== 32'h11 || ex_alu_op !== 4'd5 || ex_rd_addr !== 5'd2)
      begin errors++; $display("FAIL reset_release got v=%0b A=%h op=%0d rd=%0d want 1 11 5 2", ex_valid, ex_A, ex_alu_op, ex_rd_addr); end
  endtask

  task automatic test_ex_forwarding();
    clear_inputs();
    id_valid = 1; id_rd_addr = 3; id_reg_write = 1; id_alu_op = 4'd1;
    step();
    id_rd_addr = 8; id_rs1_addr = 3; id_rs1_used = 1; id_rs1_data = 32'h11;
    ex_alu_result = 32'h55;
    step();
    checks++; if (ex_A !== 32'h55) begin errors++; $display("FAIL ex_fwd got %h want 55", ex_A); end
    id_rd_addr = 0; id_rs1_addr = 4; id_rs1_data = 32'h21; ex_alu_result = 32'h66;
    step();
    checks++; if (ex_A !== 32'h21) begin errors++; $display("FAIL rf_no_match got %h want 21", ex_A); end
    id_rs1_addr = 0; id_rs1_data = 32'h33; ex_alu_result = 32'h77;
    step();
    checks++; if (ex_A !== 0) begin errors++; $display("FAIL x0_fwd got %h want 0", ex_A); end
  endtask

  task automatic test_priority();
    clear_inputs();
    step();
    id_valid = 1; id_rs2_addr = 4; id_rs2_used = 1; id_rs2_data = 32'h44; id_rd_addr = 9;
    mem_rd_addr = 4; mem_reg_write = 1; mem_data = 32'hAA;
    wb_rd_addr = 4; wb_reg_write = 1; wb_data = 32'hBB;
    step();
    checks++; if (ex_B !== 32'hAA || ex_store_data !== 32'hAA)
      begin errors++; $display("FAIL mem_over_wb got B=%h st=%h want AA AA", ex_B, ex_store_data); end
    id_use_imm = 1; id_imm = 32'd7;
    step();
    checks++; if (ex_B !== 32'd7 || ex_store_data !== 32'hAA)
      begin errors++; $display("FAIL imm_select got B=%h st=%h want 7 AA", ex_B, ex_store_data); end
    id_use_imm = 0; mem_reg_write = 0;
    step();
    checks++; if (ex_B !== 32'hBB) begin errors++; $display("FAIL wb_fwd got %h want BB", ex_B); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    id_valid = 1; id_rd_addr = 5; id_reg_write = 1; id_mem_read = 1;
    step();
    id_mem_read = 0; id_rd_addr = 6; id_alu_op = 4'd2;
    id_rs1_addr = 1; id_rs1_used = 1; id_rs1_data = 32'h10;
    id_rs2_addr = 5; id_rs2_used = 0; id_rs2_data = 32'h22;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hazard_unused got %0b want 0", hazard); end
    id_rs2_used = 1;
    #1;
    checks++; if (hazard !== 1'b1 || id_ready !== 1'b0)
      begin errors++; $display("FAIL hazard_detect got hz=%0b rdy=%0b want 1 0", hazard, id_ready); end
    step();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0)
      begin errors++; $display("FAIL hazard_bubble got v=%0b rw=%0b want 0 0", ex_valid, ex_reg_write); end
    checks++; if (hazard !== 1'b0 || id_ready !== 1'b1)
      begin errors++; $display("FAIL hazard_clear got hz=%0b rdy=%0b want 0 1", hazard, id_ready); end
    mem_rd_addr = 5; mem_reg_write = 1; mem_data = 32'h99;
    step();
    checks++; if (ex_valid !== 1'b1 || ex_B !== 32'h99 || ex_A !== 32'h10 || ex_alu_op !== 4'd2)
      begin errors++; $display("FAIL load_use_fwd got v=%0b A=%h B=%h op=%0d want 1 10 99 2", ex_valid, ex_A, ex_B, ex_alu_op); end
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    id_valid = 1; id_rs1_addr = 2; id_rs1_data = 32'hC0DE; id_rd_addr = 7; id_reg_write = 1; id_alu_op = 4'd3;
    step();
    stall = 1; id_rs1_addr = 7; id_rs1_data = 32'h1234; ex_alu_result = 32'hFFFF; id_alu_op = 4'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %0b want 0", i, id_ready); end
      step();
      checks++; if (ex_valid !== 1'b1 || ex_A !== 32'hC0DE || ex_alu_op !== 4'd3 || ex_rd_addr !== 5'd7)
        begin errors++; $display("FAIL stall_hold[%0d] got v=%0b A=%h op=%0d rd=%0d want 1 C0DE 3 7", i, ex_valid, ex_A, ex_alu_op, ex_rd_addr); end
    end
    flush = 1;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b want 1", id_ready); end
    step();
    checks++; if (ex_valid !== 1'b0 || ex_A !== 0 || ex_alu_op !== 0 || ex_rd_addr !== 0)
      begin errors++; $display("FAIL flush_bubble got v=%0b A=%h op=%0d rd=%0d want zeros", ex_valid, ex_A, ex_alu_op, ex_rd_addr); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_ex_forwarding();
    test_priority();
    test_load_use();
    test_stall_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
